mem_sram_controller: RTL and testbench
======================================

# mem_sram_controller

Memory-stage controller between the EXE stage register and the off-chip 16-bit SRAM. It replaces the single-cycle DataMemory for data accesses. It turns one 32-bit load or store from the pipeline into two 16-bit SRAM half-word accesses. While an access is in flight it drives `ready` low so the whole pipeline freezes.

## Interface
Parameters:
- `SRAM_ADDR_W`, 18: SRAM address width (half-word granularity).
- `PHASE_CYCLES`, 2: clock cycles per half-word access (SRAM access time plus margin), ≥1.
- `DATA_BASE`, 1024: byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset. One clock domain. The polarity and synchronicity of `rst` are fixed.
- `rd_en` in 1: load request, from EXE stage register MEM_R_EN.
- `wr_en` in 1: store request, from EXE stage register MEM_W_EN.
- `address` in 32: byte address (ALU result), word-aligned.
- `write_data` in 32: store value (ST_val).
- `read_data` out 32: loaded word, to MEM stage register.
- `ready` out 1: 0 means freeze all pipeline registers and the PC.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out SRAM_ADDR_W: SRAM half-word address.
- `SRAM_WE_N` out 1: active-low write enable.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1: tied low (always enabled).

## Operation
- States: IDLE, LOW, HIGH, DONE. A phase counter `cnt` counts 0..PHASE_CYCLES-1.
- IDLE:
  - If `wr_en` or `rd_en` is high, latch the operation type and go to LOW with `cnt`=0.
  - When `rd_en` and `wr_en` are both high, the request is treated as a store.
- LOW: access the low half-word.
  - `SRAM_ADDR` = {word_idx, 1'b0}, where word_idx = ((address − DATA_BASE) >> 2) truncated to SRAM_ADDR_W−1 bits.
  - Move to HIGH when `cnt`=PHASE_CYCLES−1.
- HIGH: access the high half-word.
  - `SRAM_ADDR` = {word_idx, 1'b1}.
  - Move to DONE when `cnt`=PHASE_CYCLES−1.
- DONE: lasts exactly one cycle, then return to IDLE.
- Stores:
  - `SRAM_DQ` is driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - `SRAM_WE_N`=0 for the whole LOW and HIGH phases; otherwise 1.
  - `SRAM_DQ` is high-Z whenever no store is active.
- Loads:
  - `SRAM_WE_N`=1 and DQ is high-Z.
  - On the last cycle of LOW, register `SRAM_DQ` into read_data[15:0]. On the last cycle of HIGH, register it into read_data[31:16].
  - `read_data` holds its value until the next load overwrites it. Stores never change it.
- `ready` (combinational): `ready` = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
- Requests that arrive outside IDLE are ignored. The frozen EXE register holds them stable, so they are never lost.
- Address bits [1:0] are ignored. Address arithmetic is modulo 2^32; out-of-range addresses wrap within SRAM.

## Timing
- Reset values (asynchronous):
  - state=IDLE, cnt=0, read_data=0.
  - SRAM_ADDR=0, SRAM_WE_N=1, DQ high-Z.
  - `ready`=1 when no request is present.
- Latency: a request seen in IDLE at edge 0 gives `ready`=0 for 2·PHASE_CYCLES+1 cycles (IDLE, LOW, HIGH). `ready`=1 in the DONE cycle.
  - With the default PHASE_CYCLES=2, an access occupies 6 cycles: 5 stalled cycles plus DONE.
- Load data: `read_data` is valid throughout DONE. The MEM stage register captures it on the DONE→IDLE edge.
- Back-to-back accesses: the pipeline advances on the DONE edge. A following request is then seen in IDLE the next cycle, so there is no idle bubble beyond IDLE itself.
- `rst` asserted mid-access: immediate return to IDLE, WE_N=1, DQ released. A partial store may be left in SRAM, which is acceptable. `read_data` is cleared.

## Structure
- Shared package `arm_pkg`:
  - state enum `sram_state_t` (IDLE, LOW, HIGH, DONE).
  - constant `DATA_BASE_ADDR` = 1024.
  - SRAM width constants (16-bit data, 18-bit address).
- No RTL sub-module: the FSM, phase counter, read-assembly register and tristate driver are inline.
- Testbench-only behavioural sub-module `sram_model`: 2^18 × 16 array, read with one cycle of combinational delay, written while WE_N=0.
- Main integration: the `ready` inverse ORs into the existing `hazard`-style freeze path. The freeze applies to the IF PC and all four stage registers.

## Test plan
- Store then load, PHASE_CYCLES=2:
  - wr_en, address=1024, write_data=0xDEADBEEF → model[0]=0xBEEF, model[1]=0xDEAD; `ready` low 5 cycles.
  - Then rd_en at 1024 → read_data=0xDEADBEEF in DONE.
- Address mapping: store 0x12345678 at address 1036 → model[6]=0x5678, model[7]=0x1234. SRAM_ADDR steps 6→7.
- Back-to-back loads at 1024 and 1028, with the request held stable under freeze → two DONE pulses exactly 6 cycles apart, correct words returned.
- rd_en and wr_en both high at 1032, data 0xA5A5_5A5A → performed as a store, and read_data is unchanged.
- Reset mid-access: assert `rst` during HIGH of a store → state=IDLE, WE_N=1, DQ=Z, read_data=0 on the same cycle. Only model[low] is updated.
- Idle: no request for 20 cycles → `ready`=1 constantly, WE_N=1, DQ never driven.

Source files
------------

// File: rtl/mem_sram_controller_pkg.sv
// rtl/mem_sram_controller_pkg.sv - shared constants and FSM encoding for the SRAM memory-stage controller
package mem_sram_controller_pkg;

    localparam int DATA_BASE_ADDR  = 1024;
    localparam int SRAM_DATA_W     = 16;
    localparam int SRAM_ADDR_W_DEF = 18;

    typedef logic [1:0] sram_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mem_sram_controller_if.sv
// rtl/mem_sram_controller_if.sv - pipeline-side load/store request bus of the SRAM controller
interface mem_sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - splits 32-bit loads/stores into two 16-bit SRAM accesses, freezing the pipeline meanwhile
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter int SRAM_ADDR_W  = SRAM_ADDR_W_DEF,
    parameter int PHASE_CYCLES = 2,
    parameter int DATA_BASE    = DATA_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_sram_controller_if.slave   bus,
    inout  wire [SRAM_DATA_W-1:0]  SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int IDX_W = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    sram_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              is_store;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_q;

    logic [31:0]       offset;
    logic [IDX_W-1:0]  word_next;
    logic              req;
    logic              phase_last;
    logic              in_access;
    logic              drive_dq;

    // Byte offset wraps modulo 2^32; the word index then wraps within the SRAM.
    assign offset     = bus.address - 32'(DATA_BASE);
    assign word_next  = IDX_W'(offset >> 2);
    assign req        = bus.rd_en | bus.wr_en;
    assign phase_last = (cnt == CNT_LAST);
    assign in_access  = (state == ST_LOW) | (state == ST_HIGH);
    assign drive_dq   = in_access & is_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_store <= 1'b0;
            word_idx <= '0;
            rd_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_LOW;
                        cnt      <= '0;
                        is_store <= bus.wr_en;
                        word_idx <= word_next;
                    end
                end
                ST_LOW: begin
                    if (phase_last) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        if (!is_store) rd_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_last) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        if (!is_store) rd_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A request sitting in IDLE already stalls; DONE releases the pipeline for one cycle.
    assign bus.ready     = (state == ST_DONE) | ((state == ST_IDLE) & ~req);
    assign bus.read_data = rd_q;

    assign SRAM_ADDR = in_access ? {word_idx, (state == ST_HIGH)} : '0;
    assign SRAM_WE_N = ~drive_dq;
    assign SRAM_DQ   = drive_dq ? ((state == ST_HIGH) ? bus.write_data[31:16] : bus.write_data[15:0])
                                : {SRAM_DATA_W{1'bz}};

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_mem_sram_controller.sv
// tb/tb_mem_sram_controller.sv - self-checking bench for mem_sram_controller with an inline SRAM model
module tb_mem_sram_controller;
    import mem_sram_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sram_controller_if bus();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    mem_sram_controller #(.SRAM_ADDR_W(18), .PHASE_CYCLES(2), .DATA_BASE(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    // SRAM: drives the bus whenever not written; probe mode returns a fixed pattern
    logic [15:0] sram [0:262143];
    logic        probe = 1'b1;
    assign sram_dq = sram_we_n ? (probe ? 16'h3C3C : sram[sram_addr]) : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] we_addrs[$];
    always @(negedge clk) if (!sram_we_n) we_addrs.push_back(sram_addr);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Higher-level reference: 32-bit words per SRAM word index, plus last loaded value
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd = 32'h0;

    function automatic int idx_of(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr - 32'd1024) >> 2;
        return int'(w % 32'h20000);
    endfunction

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit keep,
                             output int stall, output logic [31:0] rdata, output int done_cyc);
        bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = data;
        stall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) break;
            stall++;
        end
        rdata = bus.read_data;
        done_cyc = cyc;
        @(posedge clk); #1;
        if (!keep) begin
            bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          stall, dc, dc0;
        logic [31:0] rdata;
        logic [17:0] exp_steps[4];

        vecs[0] = '{"st_1024",  1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{"ld_1024",  1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{"st_1036",  1'b0, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{"ld_1036",  1'b1, 1'b0, 32'd1036, 32'h0,        32'h12345678};
        vecs[4] = '{"both_1032",1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h12345678};
        vecs[5] = '{"ld_1032",  1'b1, 1'b0, 32'd1032, 32'h0,        32'hA5A55A5A};
        vecs[6] = '{"st_1028",  1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 32'hA5A55A5A};
        vecs[7] = '{"st_1040",  1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hA5A55A5A};
        exp_steps = '{18'd6, 18'd6, 18'd7, 18'd7};

        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = 32'd0; bus.write_data = 32'hC3C3C3C3;
        #1;
        chk("rst_ready",  32'(bus.ready), 32'd1);
        chk("rst_we_n",   32'(sram_we_n), 32'd1);
        chk("rst_addr",   32'(sram_addr), 32'd0);
        chk("rst_rdata",  bus.read_data, 32'd0);
        chk("rst_dq_z",   32'(sram_dq), 32'h3C3C);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        probe = 1'b0;

        for (int i = 0; i < 8; i++) begin
            we_addrs.delete();
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, stall, rdata, dc);
            chk({vecs[i].name, "_stall"}, 32'(stall), 32'd5);
            chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            if (i == 2) begin
                chk("addr_steps_n", 32'(we_addrs.size()), 32'd4);
                for (int k = 0; k < 4 && k < we_addrs.size(); k++)
                    chk("addr_step", 32'(we_addrs[k]), 32'(exp_steps[k]));
            end
            if (vecs[i].wr) ref_mem[idx_of(vecs[i].addr)] = vecs[i].wdata;
            else            ref_rd = ref_mem[idx_of(vecs[i].addr)];
        end
        chk("sram0", 32'(sram[0]), 32'hBEEF);
        chk("sram1", 32'(sram[1]), 32'hDEAD);
        chk("sram6", 32'(sram[6]), 32'h5678);
        chk("sram7", 32'(sram[7]), 32'h1234);
        chk("sram4", 32'(sram[4]), 32'h5A5A);
        chk("sram5", 32'(sram[5]), 32'hA5A5);

        // Back-to-back loads with the request held through the freeze
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, stall, rdata, dc0);
        chk("b2b_a_stall", 32'(stall), 32'd5);
        chk("b2b_a_rdata", rdata, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, stall, rdata, dc);
        chk("b2b_b_stall", 32'(stall), 32'd5);
        chk("b2b_b_rdata", rdata, 32'h0BADF00D);
        chk("b2b_spacing", 32'(dc - dc0), 32'd6);
        ref_rd = 32'h0BADF00D;

        // Reset during the HIGH phase of a store to 1040
        probe = 1'b1;
        bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'h11112222;
        repeat (4) @(negedge clk);
        chk("mid_in_high_we", 32'(sram_we_n), 32'd0);
        chk("mid_in_high_addr", 32'(sram_addr), 32'd9);
        rst = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("mid_rst_we_n",  32'(sram_we_n), 32'd1);
        chk("mid_rst_dq_z",  32'(sram_dq), 32'h3C3C);
        chk("mid_rst_rdata", bus.read_data, 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_low_written", 32'(sram[8]), 32'h2222);
        chk("mid_high_kept",   32'(sram[9]), 32'hCAFE);
        ref_mem[4] = 32'hCAFE2222;
        ref_rd = 32'h0;

        // Idle: no request, data bus must stay released
        bus.write_data = 32'hC3C3C3C3;
        for (int c = 0; c < 20; c++) begin
            bus.address = $urandom;
            @(negedge clk);
            chk("idle_ready", 32'(bus.ready), 32'd1);
            chk("idle_we_n",  32'(sram_we_n), 32'd1);
            chk("idle_dq_z",  32'(sram_dq), 32'h3C3C);
        end
        @(posedge clk); #1;
        probe = 1'b0;

        // Randomized traffic against the word-level reference
        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr, data, exp;
            int          op, idx;
            logic        rd, wr;
            addr = 32'(1024 + 4 * (int'($urandom_range(0, 71)) - 8)) | 32'($urandom_range(0, 3));
            data = $urandom;
            op   = int'($urandom_range(0, 2));
            idx  = idx_of(addr);
            rd   = (op != 1);
            wr   = (op != 0);
            if (!wr && !ref_mem.exists(idx)) wr = 1'b1;
            do_access(rd, wr, addr, data, 1'b0, stall, rdata, dc);
            if (wr) begin
                ref_mem[idx] = data;
                exp = ref_rd;
            end else begin
                exp = ref_mem[idx];
                ref_rd = exp;
            end
            chk("rand_stall", 32'(stall), 32'd5);
            chk("rand_rdata", rdata, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
